audio_dac_write_arbiter: RTL and testbench
==========================================

// Module: audio_dac_write_arbiter
// PURPOSE
//  Shares the single write port of the audio DAC FIFO between two sample sources
//  (SD-card playback, tone/click generator). Grants whole stereo frames (L then R word)
//  so channel alignment is never broken. Paces writes with a credit model of FIFO fill,
//  since the DAC FIFO exposes no full flag. Optionally inserts silence on starvation.
//  Sits between the sample sources and the DAC FIFO iWR/iDATA/iWR_CLK inputs.
// PARAMETERS
//  DATA_WIDTH   16        sample word width
//  CHANNEL_NUM  2         words per frame (fixed 2 in this version)
//  REF_CLK      18432000  iCLK frequency, Hz
//  SAMPLE_RATE  48000     DAC frame rate, Hz
//  FIFO_DEPTH   256       DAC FIFO depth in words; credit ceiling
//  SILENCE_FILL 1         1 = write zero frame when model FIFO empty and no request
// PORTS
//  iCLK       in   1           clock; also DAC FIFO write clock
//  iRST       in   1           asynchronous, active-high reset
//  iREQ0      in   1           source 0 has a word on iDATA0
//  iDATA0     in   DATA_WIDTH  source 0 sample word (L first, then R)
//  oACK0      out  1           source 0 word consumed this cycle
//  iREQ1      in   1           source 1 request
//  iDATA1     in   DATA_WIDTH  source 1 sample word
//  oACK1      out  1           source 1 word consumed this cycle
//  oWR        out  1           DAC FIFO write strobe
//  oDATA      out  DATA_WIDTH  DAC FIFO write data
//  oGNT       out  2           one-hot current frame owner; 00 = idle/silence
//  oLEVEL     out  log2(FIFO_DEPTH)+1  modelled FIFO fill, words
//  oUNDERRUN  out  1           1-cycle pulse: drain tick with modelled level 0
// BEHAVIOUR
//  Reset: all outputs 0, level 0, rate accumulator 0, RR pointer = 1 (source 0 wins first).
//  Reset mid-frame aborts frame; no partial-frame recovery; sources must restart on L.
//  Drain tick: acc += SAMPLE_RATE*CHANNEL_NUM each cycle; when sum >= REF_CLK,
//   acc <= sum-REF_CLK, tick=1 (defaults: exactly one tick per 192 cycles). acc 32 bit.
//  Level: +1 on oWR, -1 on tick if level>0; both same cycle -> unchanged.
//   tick with level==0 and no oWR -> oUNDERRUN pulse, level stays 0. Never exceeds FIFO_DEPTH.
//  FSM IDLE, WR_L, WR_R, SIL_L, SIL_R:
//   IDLE: frame start only if level <= FIFO_DEPTH-2. One requester -> it; both -> not the
//    RR pointer's last winner. Go WR_L, set oGNT, update RR pointer.
//    No request, level==0, SILENCE_FILL -> SIL_L. Else stay.
//   WR_L: oACKn=iREQn (combinational, owner only); on ack -> WR_R.
//   WR_R: same; on ack -> IDLE. Owner dropping iREQ mid-frame: hold, no timeout, no preempt.
//   SIL_L -> SIL_R -> IDLE, one zero word per cycle, oGNT=00, no acks.
//  Latency: oWR/oDATA registered; word appears 1 cycle after its ack (or silence state cycle).
//  Max throughput 1 word/cycle; back-to-back frames allowed if credit permits.
//  Non-owner oACK is always 0; oACK0 & oACK1 never both 1.
// STRUCTURE
//  Shared package audio_pkg: FSM state encoding, REF_CLK/SAMPLE_RATE defaults,
//   level-width function clog2.
//  Sub-module audio_rate_tick: fractional accumulator producing the drain tick
//   (params REF_CLK, RATE); reusable by other audio pacing blocks.
//  Top: FSM, RR pointer, level counter, output register.
// TESTING
//  Reset, no requests, SILENCE_FILL=1 -> zero frame written cycles 1-2; oGNT=00.
//  iREQ0 held, data 0x1111/0x2222 -> oWR 2 cycles, oDATA 0x1111 then 0x2222, oLEVEL=2.
//  iREQ0 and iREQ1 held continuously -> frames alternate 0,1,0,1; no L/R split.
//  Fill to level 255 (DEPTH 256), request held -> no frame start until tick drops to 254.
//  Idle 192 cycles at level 0, SILENCE_FILL=0 -> oUNDERRUN exactly once per 192 cycles.
//  iRST asserted between L and R of source 1 -> outputs 0 immediately; next grant source 0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the audio DAC write path: arbiter FSM encoding, clock/rate
// defaults and a constant log2 helper for sizing counters.
package audio_pkg;

  localparam int unsigned RefClkDefault     = 18432000;
  localparam int unsigned SampleRateDefault = 48000;

  typedef enum logic [2:0] {
    StIdle,
    StWrL,
    StWrR,
    StSilL,
    StSilR
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/audio_rate_tick.sv
// Fractional-rate pacer: adds RATE every clock and emits a one-cycle tick each time
// the accumulator wraps past REF_CLK, giving RATE ticks per second on average.
module audio_rate_tick
  import audio_pkg::*;
#(
  parameter int unsigned REF_CLK = RefClkDefault,
  parameter int unsigned RATE    = SampleRateDefault * 2
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  logic [31:0] acc_q, acc_d;
  logic [32:0] sum;

  // One extra sum bit so the compare is exact even near the top of the 32-bit range.
  always_comb begin
    sum    = {1'b0, acc_q} + 33'(RATE);
    tick_o = (sum >= 33'(REF_CLK));
    acc_d  = tick_o ? 32'(sum - 33'(REF_CLK)) : sum[31:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/audio_dac_write_arbiter.sv
// Two-source stereo-frame arbiter for the DAC FIFO write port. Whole L/R frames are
// granted round-robin and paced by a credit model of FIFO fill drained at the frame rate.
module audio_dac_write_arbiter
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned CHANNEL_NUM  = 2,
  parameter int unsigned REF_CLK      = RefClkDefault,
  parameter int unsigned SAMPLE_RATE  = SampleRateDefault,
  parameter int unsigned FIFO_DEPTH   = 256,
  parameter bit          SILENCE_FILL = 1'b1,
  localparam int unsigned LW          = clog2(FIFO_DEPTH) + 1
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iREQ0,
  input  logic [DATA_WIDTH-1:0] iDATA0,
  output logic                  oACK0,
  input  logic                  iREQ1,
  input  logic [DATA_WIDTH-1:0] iDATA1,
  output logic                  oACK1,
  output logic                  oWR,
  output logic [DATA_WIDTH-1:0] oDATA,
  output logic [1:0]            oGNT,
  output logic [LW-1:0]         oLEVEL,
  output logic                  oUNDERRUN
);

  arb_state_e            state_q, state_d;
  logic [1:0]            gnt_q, gnt_d;
  logic                  rr_q, rr_d;   // index of the last frame winner
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  tick;
  logic                  pick;
  logic                  drain;
  logic                  can_start;

  audio_rate_tick #(
    .REF_CLK (REF_CLK),
    .RATE    (SAMPLE_RATE * CHANNEL_NUM)
  ) u_rate_tick (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .tick_o (tick)
  );

  // Room for a whole frame is judged on the committed level only.
  assign can_start = (level_q <= LW'(FIFO_DEPTH - 2));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      rr_q    <= 1'b1;
      wr_q    <= 1'b0;
      data_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    pick    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (can_start && (iREQ0 || iREQ1)) begin
          pick    = (iREQ0 && iREQ1) ? ~rr_q : iREQ1;
          state_d = StWrL;
          gnt_d   = pick ? 2'b10 : 2'b01;
          rr_d    = pick;
        end else if (!iREQ0 && !iREQ1 && (level_q == '0) && SILENCE_FILL) begin
          state_d = StSilL;
        end
      end
      StWrL: begin
        if (oACK0 || oACK1) state_d = StWrR;
      end
      StWrR: begin
        if (oACK0 || oACK1) begin
          state_d = StIdle;
          gnt_d   = '0;
        end
      end
      StSilL:  state_d = StSilR;
      StSilR:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    oACK0 = 1'b0;
    oACK1 = 1'b0;
    if (state_q == StWrL || state_q == StWrR) begin
      oACK0 = gnt_q[0] && iREQ0;
      oACK1 = gnt_q[1] && iREQ1;
    end
  end

  always_comb begin
    wr_d   = oACK0 || oACK1 || (state_q == StSilL) || (state_q == StSilR);
    data_d = oACK0 ? iDATA0 : (oACK1 ? iDATA1 : '0);

    drain   = tick && (level_q != '0);
    level_d = level_q;
    if (wr_q && !drain) begin
      if (level_q < LW'(FIFO_DEPTH)) level_d = level_q + LW'(1);
    end else if (!wr_q && drain) begin
      level_d = level_q - LW'(1);
    end
  end

  assign oWR       = wr_q;
  assign oDATA     = data_q;
  assign oGNT      = gnt_q;
  assign oLEVEL    = level_q;
  assign oUNDERRUN = tick && (level_q == '0) && !wr_q;

endmodule

// File: tb/tb_audio_dac_write_arbiter.sv
// Bench for audio_dac_write_arbiter: random sources checked every cycle against a
// frame-level model, plus directed literal checks of the headline behaviours.
module tb_audio_dac_write_arbiter;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 256;
  localparam longint      REF   = 18432000;
  localparam longint      RATE  = 96000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [DW-1:0] data0 = '0, data1 = '0;
  logic          ack0, ack1, wr, underrun;
  logic [DW-1:0] wdata;
  logic [1:0]    gnt;
  logic [8:0]    level;

  logic          ack0_b, ack1_b, wr_b, underrun_b;
  logic [DW-1:0] wdata_b;
  logic [1:0]    gnt_b;
  logic [8:0]    level_b;
  logic          zero = 1'b0;
  logic [DW-1:0] zero_w = '0;

  audio_dac_write_arbiter #(.SILENCE_FILL(1'b1)) dut (
    .iCLK(clk), .iRST(rst),
    .iREQ0(req0), .iDATA0(data0), .oACK0(ack0),
    .iREQ1(req1), .iDATA1(data1), .oACK1(ack1),
    .oWR(wr), .oDATA(wdata), .oGNT(gnt), .oLEVEL(level), .oUNDERRUN(underrun)
  );

  // Idle instance without silence fill: every drain tick must flag an underrun.
  audio_dac_write_arbiter #(.SILENCE_FILL(1'b0)) dut_nofill (
    .iCLK(clk), .iRST(rst),
    .iREQ0(zero), .iDATA0(zero_w), .oACK0(ack0_b),
    .iREQ1(zero), .iDATA1(zero_w), .oACK1(ack1_b),
    .oWR(wr_b), .oDATA(wdata_b), .oGNT(gnt_b), .oLEVEL(level_b), .oUNDERRUN(underrun_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int unsigned p0 = 0, p1 = 0;
  int cnt0 = 0, cnt1 = 0;

  // Model: frame owner (-1 none, 0/1 source, 2 silence) and words still to send.
  longint        m_acc;
  int            m_level, m_owner, m_left, m_last;
  bit            m_wr;
  logic [DW-1:0] m_data;

  logic [1:0] prev_gnt;
  int         prev_level, max_level, u2_count, u2_first;
  logic [1:0] gnt_starts[$];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] src_word(input int s, input int k);
    if (s == 0) return DW'(32'h1111 * ((k % 14) + 1));
    return DW'(32'hA000 + k);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_acc = 0; m_level = 0; m_owner = -1; m_left = 0; m_last = 1;
    m_wr = 1'b0; m_data = '0;
    cnt0 = 0; cnt1 = 0; cyc = 0;
    prev_gnt = '0; prev_level = 0; max_level = 0;
    u2_count = 0; u2_first = -1;
    gnt_starts.delete();
  endtask

  task automatic check_cycle();
    longint        sum;
    bit            tick, e_ack0, e_ack1;
    logic [1:0]    e_gnt;
    int            n_level, w;
    bit            n_wr;
    logic [DW-1:0] n_data;

    sum    = m_acc + RATE;
    tick   = (sum >= REF);
    e_gnt  = (m_owner == 0) ? 2'b01 : ((m_owner == 1) ? 2'b10 : 2'b00);
    e_ack0 = (m_owner == 0) && req0;
    e_ack1 = (m_owner == 1) && req1;

    chk("wr", wr, m_wr);
    if (m_wr) chk("data", wdata, m_data);
    chk("gnt", gnt, e_gnt);
    chk("level", level, m_level);
    chk("ack0", ack0, e_ack0);
    chk("ack1", ack1, e_ack1);
    chk("underrun", underrun, tick && m_level == 0 && !m_wr);
    chk("nofill_underrun", underrun_b, tick);
    chk("nofill_wr", wr_b, 0);
    chk("nofill_level", level_b, 0);

    if (underrun_b && u2_first < 0) u2_first = cyc;
    if (underrun_b) u2_count++;
    if (prev_gnt == 2'b00 && gnt != 2'b00) begin
      gnt_starts.push_back(gnt);
      chk("credit_at_start", prev_level <= DEPTH - 2, 1);
    end
    prev_gnt   = gnt;
    prev_level = int'(level);
    if (int'(level) > max_level) max_level = int'(level);

    if (m_wr && !(tick && m_level > 0)) n_level = (m_level < DEPTH) ? m_level + 1 : m_level;
    else if (!m_wr && tick && m_level > 0) n_level = m_level - 1;
    else n_level = m_level;

    n_wr = 1'b0;
    n_data = '0;
    if (m_owner == 2) begin
      n_wr = 1'b1;
      m_left--;
    end else if (m_owner >= 0) begin
      if (e_ack0 || e_ack1) begin
        n_wr   = 1'b1;
        n_data = e_ack0 ? data0 : data1;
        m_left--;
      end
    end else if (m_level <= DEPTH - 2 && (req0 || req1)) begin
      w = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
      m_owner = w; m_left = 2; m_last = w;
    end else if (!req0 && !req1 && m_level == 0) begin
      m_owner = 2; m_left = 2;
    end
    if (m_owner != -1 && m_left == 0) m_owner = -1;

    m_level = n_level;
    m_wr    = n_wr;
    m_data  = n_data;
    m_acc   = tick ? sum - REF : sum;
    if (e_ack0) cnt0++;
    if (e_ack1) cnt1++;
    cyc++;
  endtask

  task automatic step();
    req0  = ($urandom_range(99) < p0);
    req1  = ($urandom_range(99) < p1);
    data0 = src_word(0, cnt0);
    data1 = src_word(1, cnt1);
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] alt_exp[4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    // Reset state and silence frame with nobody requesting.
    do_reset();
    p0 = 0; p1 = 0;
    chk("rst_wr", wr, 0);
    chk("rst_level", level, 0);
    chk("rst_gnt", gnt, 0);
    step();
    chk("sil_c1_wr", wr, 0);
    step();
    chk("sil_c2_wr", wr, 1);
    chk("sil_c2_data", wdata, 0);
    chk("sil_c2_gnt", gnt, 0);
    step();
    chk("sil_c3_wr", wr, 1);
    chk("sil_c3_data", wdata, 0);
    step();
    chk("sil_c4_level", level, 2);
    chk("sil_c4_wr", wr, 0);

    // Source 0 alone: 0x1111 then 0x2222.
    do_reset();
    p0 = 100; p1 = 0;
    repeat (2) step();
    chk("s0_c2_wr", wr, 1);
    chk("s0_c2_data", wdata, 16'h1111);
    step();
    chk("s0_c3_wr", wr, 1);
    chk("s0_c3_data", wdata, 16'h2222);
    step();
    chk("s0_c4_level", level, 2);

    // Both held: frame owners alternate 0,1,0,1.
    do_reset();
    p0 = 100; p1 = 100;
    repeat (14) step();
    for (int i = 0; i < 4; i++) begin
      chk("alternate", (i < gnt_starts.size()) ? gnt_starts[i] : 2'b00, alt_exp[i]);
    end

    // Source 0 held long enough to hit the credit ceiling.
    do_reset();
    p0 = 100; p1 = 0;
    repeat (700) step();
    chk("fill_ceiling", max_level <= DEPTH, 1);
    chk("fill_reached", int'(level) >= DEPTH - 6, 1);

    // Reset between L and R of a source-1 frame.
    do_reset();
    p0 = 0; p1 = 100;
    step();
    step();
    chk("midrst_gnt_before", gnt, 2'b10);
    rst = 1'b1;
    #1;
    chk("midrst_ack1", ack1, 0);
    chk("midrst_wr", wr, 0);
    chk("midrst_gnt", gnt, 0);
    chk("midrst_level", level, 0);
    do_reset();
    p0 = 100; p1 = 100;
    step();
    chk("midrst_next_owner", gnt, 2'b01);

    // Random traffic with varying request densities.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      p0 = $urandom_range(100);
      p1 = $urandom_range(100);
      repeat (400) step();
    end

    // Long idle: underrun cadence on the no-fill instance.
    do_reset();
    p0 = 0; p1 = 0;
    repeat (960) step();
    chk("underrun_count", u2_count, 5);
    chk("underrun_first", u2_first, 191);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
